// File: rtl/ssm_mem_pkg.sv
// Shared types and helpers for the wait-state main memory (mem_unit).
// Holds the sequencer state encoding, the wait counter width and the
// even-parity helper used when the parity build is enabled.
package ssm_mem_pkg;

  // Sequencer states; the unused code 2'd3 is treated as IDLE by the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wait counter width; covers the legal WAIT_CYCLES range 0..15.
  localparam int CNT_W = 4;

  // Even parity over a word of up to 64 bits; callers zero-extend,
  // which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM behind mem_unit.
// The storage itself is never reset; only the registered read port is,
// so the read data seen by the MDR starts at zero after reset.
module mem_array #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Storage write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Registered read port; holds its value until the next read access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_unit.sv
// Word-addressed main memory with programmable wait states and a
// ready/done handshake toward the control sequencer.
// A request is latched in IDLE, held for WAIT_CYCLES counts, performed
// at the access edge and announced with a one-cycle done pulse.
// Optional build macro: MEM_PARITY_EN adds a stored even-parity bit,
// the MEM_parity_inject input and the MEM_parity_err output.
module mem_unit
  import ssm_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              MEM_clock,
  input  logic              MEM_reset_n,
  input  logic [15:0]       MEM_addr,
  input  logic [DATA_W-1:0] MEM_data_in,
  input  logic              MEM_read,
  input  logic              MEM_write,
`ifdef MEM_PARITY_EN
  input  logic              MEM_parity_inject,
  output logic              MEM_parity_err,
`endif
  output logic [DATA_W-1:0] MEM_data_out,
  output logic              MEM_ready,
  output logic              MEM_done
);

`ifdef MEM_PARITY_EN
  localparam int ARR_W = DATA_W + 1;
`else
  localparam int ARR_W = DATA_W;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               op_write_q;
  logic               ready_q;
  logic               done_q;

  logic               access;
  logic               arr_we;
  logic               arr_re;
  logic [ARR_W-1:0]   arr_din;
  logic [ARR_W-1:0]   arr_dout;

  // Address bits above ADDR_W alias onto the implemented depth.
  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^MEM_addr[15:ADDR_W];
    end
  endgenerate

  // The access edge is the WAIT edge on which the counter has run out.
  assign access = (state == WAIT) && (cnt == '0);
  assign arr_we = access && op_write_q;
  assign arr_re = access && !op_write_q;

`ifdef MEM_PARITY_EN
  // Stored parity bit; inject flips it to model a corrupted word.
  assign arr_din = {even_parity(64'(data_q)) ^ MEM_parity_inject, data_q};
  assign MEM_data_out = arr_dout[DATA_W-1:0];
  // A clean word XORs to zero including its parity bit; only reads flag.
  assign MEM_parity_err = done_q && !op_write_q && (^arr_dout);
`else
  assign arr_din = data_q;
  assign MEM_data_out = arr_dout;
`endif

  assign MEM_ready = ready_q;
  assign MEM_done  = done_q;

  // Sequencer: latch a request in IDLE, count wait states, pulse done.
  always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
    if (!MEM_reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_write_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (MEM_write || MEM_read) begin
            addr_q     <= MEM_addr[ADDR_W-1:0];
            data_q     <= MEM_data_in;
            op_write_q <= MEM_write;
            cnt        <= CNT_W'(WAIT_CYCLES);
            state      <= WAIT;
            ready_q    <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  mem_array #(
    .WIDTH  (ARR_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (MEM_clock),
    .rst_n (MEM_reset_n),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q),
    .din   (arr_din),
    .dout  (arr_dout)
  );

endmodule
